// File: rtl/mem_access.sv
// mem_access: RV32I memory stage. Latches the alu slot, performs load/store
// on a single-beat req/ack bus, extends load data, and drives writeback
// and the forwarding bus back into alu.
// Optional feature macro: MEM_MISALIGN_TRAP_EN (misaligned accesses skip the
// bus and complete with value 0; adds m_misalign_o).
// Parameter: TIMEOUT_CYCLES - BUSY cycles allowed before abort, 0 = never.
// Ports:
//   clk, rst_n               clock, async active-low reset
//   stall_i, flush_i         hold / clear pipeline registers
//   a_*_i                    slot from alu (pc, inst, valid, rd, value, mem ctrl)
//   mem_req/we/addr/strb/wdata_o, mem_ack_i, mem_rdata_i   data bus
//   mem_stall_o              access pending (combinational)
//   mem_bus_err_o            one-cycle pulse on timeout abort
//   m_*_o                    writeback slot
//   fwd_m_*_o                forwarding bus to alu
module mem_access #(
   parameter int unsigned TIMEOUT_CYCLES = 64
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        stall_i,
   input  logic        flush_i,
   input  logic [31:0] a_pc_i,
   input  logic [31:0] a_inst_i,
   input  logic        a_valid_i,
   input  logic [4:0]  a_reg_d_i,
   input  logic [31:0] a_reg_d_v_i,
   input  logic        a_mem_re_i,
   input  logic        a_mem_we_i,
   input  logic [31:0] a_mem_addr_i,
   input  logic [3:0]  a_mem_strb_i,
   input  logic [31:0] a_mem_wdata_i,
   output logic        mem_req_o,
   output logic        mem_we_o,
   output logic [31:0] mem_addr_o,
   output logic [3:0]  mem_strb_o,
   output logic [31:0] mem_wdata_o,
   input  logic        mem_ack_i,
   input  logic [31:0] mem_rdata_i,
   output logic        mem_stall_o,
   output logic        mem_bus_err_o,
   output logic [31:0] m_pc_o,
   output logic [31:0] m_inst_o,
   output logic        m_valid_o,
   output logic [4:0]  m_reg_d_o,
   output logic [31:0] m_reg_d_v_o,
   output logic        fwd_m_valid_o,
   output logic [4:0]  fwd_m_reg_d_o,
   output logic [31:0] fwd_m_reg_d_v_o
`ifdef MEM_MISALIGN_TRAP_EN
   ,
   output logic        m_misalign_o
`endif
);

   localparam int unsigned CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES + 1) : 1;

   typedef enum logic [1:0] {IDLE, BUSY, DONE} state_e;

   state_e             state_q, state_d;
   logic [CNT_W-1:0]   cnt_q, cnt_d;
   logic [31:0]        rdata_q, rdata_d;
   logic               err_q, err_d;
   logic               bus_we_q, bus_we_d;
   logic [31:0]        bus_addr_q, bus_addr_d;
   logic [3:0]         bus_strb_q, bus_strb_d;
   logic [31:0]        bus_wdata_q, bus_wdata_d;

   logic               valid_q, re_q, we_q, mis_q;
   logic [31:0]        pc_q, inst_q, rdv_q, addr_q;
   logic [4:0]         rd_q;

   logic               busy_c, cap_c, acc_c, mis_c, slot_free_c, start_c, trap_c, tmo_c;
   logic [31:0]        rdata_c, shifted_c, load_c;

   assign busy_c      = (state_q == BUSY);
   assign cap_c       = !flush_i && !stall_i;
   assign acc_c       = a_valid_i && (a_mem_re_i || a_mem_we_i);
   // a new access may only claim the bus once the current one is acknowledged
   assign slot_free_c = !busy_c || mem_ack_i;

`ifdef MEM_MISALIGN_TRAP_EN
   // halfword: addr[0] set; word: any low address bit set
   assign mis_c = acc_c &&
                  (((a_inst_i[13:12] == 2'b01) && a_mem_addr_i[0]) ||
                   ((a_inst_i[13:12] == 2'b10) && (a_mem_addr_i[1:0] != 2'b00)));
`else
   assign mis_c = 1'b0;
`endif

   assign start_c = cap_c && acc_c && !mis_c && slot_free_c;
   assign trap_c  = cap_c && mis_c && slot_free_c;
   assign tmo_c   = busy_c && !mem_ack_i && (TIMEOUT_CYCLES != 0) &&
                    (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));

   // FSM state and bus-side registers
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= IDLE;
         cnt_q       <= '0;
         rdata_q     <= '0;
         err_q       <= 1'b0;
         bus_we_q    <= 1'b0;
         bus_addr_q  <= '0;
         bus_strb_q  <= '0;
         bus_wdata_q <= '0;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         rdata_q     <= rdata_d;
         err_q       <= err_d;
         bus_we_q    <= bus_we_d;
         bus_addr_q  <= bus_addr_d;
         bus_strb_q  <= bus_strb_d;
         bus_wdata_q <= bus_wdata_d;
      end
   end

   // next state, timeout counter, read-data latch
   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      rdata_d     = rdata_q;
      err_d       = 1'b0;
      bus_we_d    = bus_we_q;
      bus_addr_d  = bus_addr_q;
      bus_strb_d  = bus_strb_q;
      bus_wdata_d = bus_wdata_q;
      case (state_q)
         IDLE: begin
            if (start_c)     state_d = BUSY;
            else if (trap_c) state_d = DONE;
         end
         BUSY: begin
            if (mem_ack_i) begin
               rdata_d = mem_rdata_i;
               if (start_c)                 state_d = BUSY;
               else if (trap_c)             state_d = DONE;
               else if (cap_c || flush_i)   state_d = IDLE;
               else                         state_d = DONE;
            end else if (tmo_c) begin
               rdata_d = '0;
               err_d   = 1'b1;
               state_d = DONE;
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end
         DONE: begin
            if (start_c)                 state_d = BUSY;
            else if (trap_c)             state_d = DONE;
            else if (cap_c || flush_i)   state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
      if (start_c) begin
         cnt_d       = '0;
         bus_we_d    = a_mem_we_i;
         bus_addr_d  = {a_mem_addr_i[31:2], 2'b00};
         bus_strb_d  = a_mem_we_i ? a_mem_strb_i : 4'hF;
         bus_wdata_d = a_mem_wdata_i;
      end
      if (trap_c) rdata_d = '0;
   end

   // pipeline slot registers
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         valid_q <= 1'b0; re_q <= 1'b0; we_q <= 1'b0; mis_q <= 1'b0;
         pc_q <= '0; inst_q <= '0; rdv_q <= '0; addr_q <= '0; rd_q <= '0;
      end else if (flush_i) begin
         valid_q <= 1'b0; re_q <= 1'b0; we_q <= 1'b0; mis_q <= 1'b0;
         pc_q <= '0; inst_q <= '0; rdv_q <= '0; addr_q <= '0; rd_q <= '0;
      end else if (!stall_i) begin
         valid_q <= a_valid_i;
         re_q    <= a_mem_re_i;
         we_q    <= a_mem_we_i;
         mis_q   <= mis_c;
         pc_q    <= a_pc_i;
         inst_q  <= a_inst_i;
         rdv_q   <= a_reg_d_v_i;
         addr_q  <= a_mem_addr_i;
         rd_q    <= a_reg_d_i;
      end
   end

   // load data: live bus data on the ack cycle, latched copy afterwards
   assign rdata_c   = (busy_c && mem_ack_i) ? mem_rdata_i : rdata_q;
   assign shifted_c = rdata_c >> {addr_q[1:0], 3'b000};

   always_comb begin
      load_c = rdata_c;
      case (inst_q[14:12])
         3'b000:  load_c = {{24{shifted_c[7]}}, shifted_c[7:0]};
         3'b001:  load_c = {{16{shifted_c[15]}}, shifted_c[15:0]};
         3'b100:  load_c = {24'h0, shifted_c[7:0]};
         3'b101:  load_c = {16'h0, shifted_c[15:0]};
         default: load_c = rdata_c;
      endcase
   end

   assign mem_req_o       = busy_c;
   assign mem_we_o        = bus_we_q;
   assign mem_addr_o      = bus_addr_q;
   assign mem_strb_o      = bus_strb_q;
   assign mem_wdata_o     = bus_wdata_q;
   assign mem_stall_o     = busy_c && !mem_ack_i;
   assign mem_bus_err_o   = err_q;

   assign m_pc_o          = pc_q;
   assign m_inst_o        = inst_q;
   assign m_valid_o       = valid_q &&
                            (!(re_q || we_q) || (state_q == DONE) || (busy_c && mem_ack_i));
   assign m_reg_d_o       = rd_q;
   assign m_reg_d_v_o     = re_q ? load_c : rdv_q;

   assign fwd_m_valid_o   = m_valid_o && (rd_q != 5'd0) && !we_q;
   assign fwd_m_reg_d_o   = rd_q;
   assign fwd_m_reg_d_v_o = m_reg_d_v_o;

`ifdef MEM_MISALIGN_TRAP_EN
   assign m_misalign_o    = valid_q && mis_q;
`endif

endmodule

// File: tb/tb_mem_access.sv
module tb_mem_access;

   localparam int unsigned TMO = 4;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        ext_stall, flush;
   logic [31:0] a_pc, a_inst, a_reg_d_v, a_mem_addr, a_mem_wdata;
   logic        a_valid, a_mem_re, a_mem_we;
   logic [4:0]  a_reg_d;
   logic [3:0]  a_mem_strb;
   logic        mem_req, mem_we, mem_ack, mem_stall, mem_bus_err;
   logic [31:0] mem_addr, mem_wdata, mem_rdata;
   logic [3:0]  mem_strb;
   logic [31:0] m_pc, m_inst, m_reg_d_v, fwd_m_reg_d_v;
   logic        m_valid, fwd_m_valid;
   logic [4:0]  m_reg_d, fwd_m_reg_d;
   logic        stall;
`ifdef MEM_MISALIGN_TRAP_EN
   logic        m_misalign;
`endif

   int total = 0;
   int bad   = 0;

   always #5 clk = ~clk;

   // global stall as the pipeline would build it
   assign stall = ext_stall | mem_stall;

   mem_access #(.TIMEOUT_CYCLES(TMO)) dut (
      .clk(clk), .rst_n(rst_n), .stall_i(stall), .flush_i(flush),
      .a_pc_i(a_pc), .a_inst_i(a_inst), .a_valid_i(a_valid), .a_reg_d_i(a_reg_d),
      .a_reg_d_v_i(a_reg_d_v), .a_mem_re_i(a_mem_re), .a_mem_we_i(a_mem_we),
      .a_mem_addr_i(a_mem_addr), .a_mem_strb_i(a_mem_strb), .a_mem_wdata_i(a_mem_wdata),
      .mem_req_o(mem_req), .mem_we_o(mem_we), .mem_addr_o(mem_addr),
      .mem_strb_o(mem_strb), .mem_wdata_o(mem_wdata), .mem_ack_i(mem_ack),
      .mem_rdata_i(mem_rdata), .mem_stall_o(mem_stall), .mem_bus_err_o(mem_bus_err),
      .m_pc_o(m_pc), .m_inst_o(m_inst), .m_valid_o(m_valid), .m_reg_d_o(m_reg_d),
      .m_reg_d_v_o(m_reg_d_v), .fwd_m_valid_o(fwd_m_valid), .fwd_m_reg_d_o(fwd_m_reg_d),
      .fwd_m_reg_d_v_o(fwd_m_reg_d_v)
`ifdef MEM_MISALIGN_TRAP_EN
      , .m_misalign_o(m_misalign)
`endif
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
      end
   endtask

   // reference load extension built from a byte view of the bus word
   function automatic logic [31:0] ref_load(input logic [2:0] f3, input logic [1:0] lo,
                                           input logic [31:0] word);
      int by [4];
      int v;
      for (int i = 0; i < 4; i++) by[i] = int'(word[8*i +: 8]);
      case (f3)
         3'd0: begin v = by[lo]; if (v >= 128) v -= 256; end
         3'd1: begin v = by[lo] + 256 * by[lo + 1]; if (v >= 32768) v -= 65536; end
         3'd4: v = by[lo];
         3'd5: v = by[lo] + 256 * by[lo + 1];
         default: return word;
      endcase
      return 32'(v);
   endfunction

   task automatic set_a(input logic v, input logic re, input logic we, input logic [2:0] f3,
                        input logic [31:0] addr, input logic [4:0] rd, input logic [31:0] rdv,
                        input logic [31:0] wdata, input logic [3:0] strb);
      a_valid     = v;
      a_mem_re    = re;
      a_mem_we    = we;
      a_inst      = {17'h0, f3, rd, re ? 7'h03 : (we ? 7'h23 : 7'h13)};
      a_pc        = $urandom;
      a_mem_addr  = addr;
      a_reg_d     = rd;
      a_reg_d_v   = rdv;
      a_mem_wdata = wdata;
      a_mem_strb  = strb;
   endtask

   task automatic bubble();
      set_a(1'b0, 1'b0, 1'b0, 3'd0, 32'h0, 5'd0, 32'h0, 32'h0, 4'h0);
   endtask

   // one load/store; entered and left at posedge+1 with the bus idle
   task automatic run_access(input string tag, input logic is_ld, input logic [2:0] f3,
                             input logic [31:0] addr, input logic [4:0] rd,
                             input logic [31:0] wdata, input logic [3:0] strb,
                             input logic [31:0] rdata, input int lat, input bit hold);
      logic [31:0] rdv, exp_v;
      rdv   = $urandom;
      exp_v = is_ld ? ref_load(f3, addr[1:0], rdata) : rdv;
      set_a(1'b1, is_ld, !is_ld, f3, addr, rd, rdv, wdata, strb);
      @(posedge clk); #1;
      bubble();
      mem_ack = 1'b0;
      for (int c = 0; c < lat; c++) begin
         @(negedge clk);
         chk({tag, " wait req"},   32'(mem_req), 32'd1);
         chk({tag, " wait stall"}, 32'(mem_stall), 32'd1);
         chk({tag, " wait valid"}, 32'(m_valid), 32'd0);
         chk({tag, " addr"},       mem_addr, {addr[31:2], 2'b00});
         @(posedge clk); #1;
      end
      mem_ack   = 1'b1;
      mem_rdata = rdata;
      if (hold) ext_stall = 1'b1;
      @(negedge clk);
      chk({tag, " ack req"},   32'(mem_req), 32'd1);
      chk({tag, " ack stall"}, 32'(mem_stall), 32'd0);
      chk({tag, " we"},        32'(mem_we), 32'(!is_ld));
      chk({tag, " strb"},      32'(mem_strb), is_ld ? 32'hF : 32'(strb));
      if (!is_ld) chk({tag, " wdata"}, mem_wdata, wdata);
      chk({tag, " m_valid"},   32'(m_valid), 32'd1);
      chk({tag, " m_reg_d"},   32'(m_reg_d), 32'(rd));
      chk({tag, " value"},     m_reg_d_v, exp_v);
      chk({tag, " fwd_valid"}, 32'(fwd_m_valid), 32'(is_ld && (rd != 5'd0)));
      chk({tag, " fwd_v"},     fwd_m_reg_d_v, exp_v);
      chk({tag, " bus_err"},   32'(mem_bus_err), 32'd0);
      @(posedge clk); #1;
      mem_ack   = 1'b0;
      mem_rdata = $urandom;
      if (hold) begin
         @(negedge clk);
         chk({tag, " hold req"},   32'(mem_req), 32'd0);
         chk({tag, " hold valid"}, 32'(m_valid), 32'd1);
         chk({tag, " hold value"}, m_reg_d_v, exp_v);
         @(posedge clk); #1;
         ext_stall = 1'b0;
      end
      @(negedge clk);
      chk({tag, " end req"}, 32'(mem_req), 32'd0);
      if (!hold) chk({tag, " end valid"}, 32'(m_valid), 32'd0);
      @(posedge clk); #1;
   endtask

   task automatic run_alu(input string tag, input logic [4:0] rd, input logic [31:0] v);
      logic [31:0] pc;
      set_a(1'b1, 1'b0, 1'b0, 3'd0, $urandom, rd, v, 32'h0, 4'h0);
      pc = a_pc;
      @(posedge clk); #1;
      bubble();
      @(negedge clk);
      chk({tag, " req"},       32'(mem_req), 32'd0);
      chk({tag, " m_valid"},   32'(m_valid), 32'd1);
      chk({tag, " m_pc"},      m_pc, pc);
      chk({tag, " fwd_valid"}, 32'(fwd_m_valid), 32'(rd != 5'd0));
      chk({tag, " fwd_rd"},    32'(fwd_m_reg_d), 32'(rd));
      chk({tag, " fwd_v"},     fwd_m_reg_d_v, v);
      @(posedge clk); #1;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [2:0] ld_f3 [5];
      logic [2:0] st_f3 [3];
      logic [31:0] base, addr;
      logic [2:0]  f3;
      logic [3:0]  strb;
      int          kind;

      ld_f3 = '{3'd0, 3'd1, 3'd2, 3'd4, 3'd5};
      st_f3 = '{3'd0, 3'd1, 3'd2};

      rst_n = 1'b0; ext_stall = 1'b0; flush = 1'b0;
      mem_ack = 1'b0; mem_rdata = 32'h0;
      bubble();
      #1;
      chk("rst req",       32'(mem_req), 32'd0);
      chk("rst stall",     32'(mem_stall), 32'd0);
      chk("rst m_valid",   32'(m_valid), 32'd0);
      chk("rst fwd_valid", 32'(fwd_m_valid), 32'd0);
      chk("rst bus_err",   32'(mem_bus_err), 32'd0);
      chk("rst m_reg_d_v", m_reg_d_v, 32'd0);
      @(posedge clk); @(posedge clk); #1;
      rst_n = 1'b1;
      @(posedge clk); #1;

      // directed cases
      run_access("lw100",  1'b1, 3'd2, 32'h100, 5'd1, 32'h0, 4'h0, 32'hDEADBEEF, 3, 1'b0);
      run_access("lb103",  1'b1, 3'd0, 32'h103, 5'd2, 32'h0, 4'h0, 32'h80FF0000, 1, 1'b0);
      run_access("lbu103", 1'b1, 3'd4, 32'h103, 5'd2, 32'h0, 4'h0, 32'h80FF0000, 0, 1'b0);
      run_access("lhu102", 1'b1, 3'd5, 32'h102, 5'd2, 32'h0, 4'h0, 32'h80FF0000, 2, 1'b0);
      run_access("sw200",  1'b0, 3'd2, 32'h200, 5'd3, 32'h12345678, 4'hF, 32'h0, 0, 1'b0);
      run_access("lw_x0",  1'b1, 3'd2, 32'h104, 5'd0, 32'h0, 4'h0, 32'h0BADF00D, 1, 1'b1);
      run_alu("addi", 5'd5, 32'd7);
      run_alu("addi_x0", 5'd0, 32'd9);

      // timeout: no ack ever arrives
      set_a(1'b1, 1'b1, 1'b0, 3'd2, 32'h300, 5'd7, 32'h55, 32'h0, 4'h0);
      @(posedge clk); #1;
      bubble();
      for (int c = 0; c < int'(TMO); c++) begin
         @(negedge clk);
         chk("tmo req",   32'(mem_req), 32'd1);
         chk("tmo err0",  32'(mem_bus_err), 32'd0);
         @(posedge clk); #1;
      end
      @(negedge clk);
      chk("tmo req drop", 32'(mem_req), 32'd0);
      chk("tmo err",      32'(mem_bus_err), 32'd1);
      chk("tmo valid",    32'(m_valid), 32'd1);
      chk("tmo value",    m_reg_d_v, 32'd0);
      @(posedge clk); #1;
      @(negedge clk);
      chk("tmo err pulse", 32'(mem_bus_err), 32'd0);
      chk("tmo retire",    32'(m_valid), 32'd0);
      @(posedge clk); #1;

      // ack and next capture on the same edge
      set_a(1'b1, 1'b1, 1'b0, 3'd2, 32'h40, 5'd3, 32'h0, 32'h0, 4'h0);
      @(posedge clk); #1;
      set_a(1'b1, 1'b1, 1'b0, 3'd5, 32'h86, 5'd4, 32'h0, 32'h0, 4'h0);
      @(negedge clk);
      chk("b2b first stall", 32'(mem_stall), 32'd1);
      @(posedge clk); #1;
      mem_ack = 1'b1; mem_rdata = 32'hCAFE1234;
      @(negedge clk);
      chk("b2b first value", m_reg_d_v, 32'hCAFE1234);
      @(posedge clk); #1;
      bubble();
      mem_ack = 1'b0;
      @(negedge clk);
      chk("b2b second req",  32'(mem_req), 32'd1);
      chk("b2b second addr", mem_addr, 32'h84);
      chk("b2b second rd",   32'(m_reg_d), 32'd4);
      chk("b2b second wait", 32'(m_valid), 32'd0);
      @(posedge clk); #1;
      mem_ack = 1'b1; mem_rdata = 32'hA5B6C7D8;
      @(negedge clk);
      chk("b2b second value", m_reg_d_v, ref_load(3'd5, 2'd2, 32'hA5B6C7D8));
      @(posedge clk); #1;
      mem_ack = 1'b0;

      // flush while the bus is busy
      set_a(1'b1, 1'b1, 1'b0, 3'd2, 32'h500, 5'd6, 32'h0, 32'h0, 4'h0);
      @(posedge clk); #1;
      bubble();
      flush = 1'b1;
      @(posedge clk); #1;
      flush = 1'b0;
      @(negedge clk);
      chk("flush req held",   32'(mem_req), 32'd1);
      chk("flush stall held", 32'(mem_stall), 32'd1);
      chk("flush valid",      32'(m_valid), 32'd0);
      @(posedge clk); #1;
      mem_ack = 1'b1; mem_rdata = 32'h11112222;
      @(negedge clk);
      chk("flush ack valid", 32'(m_valid), 32'd0);
      chk("flush ack fwd",   32'(fwd_m_valid), 32'd0);
      @(posedge clk); #1;
      mem_ack = 1'b0;
      @(negedge clk);
      chk("flush end req", 32'(mem_req), 32'd0);
      @(posedge clk); #1;

      // asynchronous reset in the middle of an access
      set_a(1'b1, 1'b1, 1'b0, 3'd2, 32'h600, 5'd8, 32'h0, 32'h0, 4'h0);
      @(posedge clk); #1;
      bubble();
      @(negedge clk);
      chk("arst before req", 32'(mem_req), 32'd1);
      #2 rst_n = 1'b0;
      #1;
      chk("arst req",   32'(mem_req), 32'd0);
      chk("arst stall", 32'(mem_stall), 32'd0);
      @(posedge clk); #1;
      rst_n = 1'b1;
      @(posedge clk); #1;

`ifdef MEM_MISALIGN_TRAP_EN
      set_a(1'b1, 1'b1, 1'b0, 3'd2, 32'h102, 5'd9, 32'h0, 32'h0, 4'h0);
      @(posedge clk); #1;
      bubble();
      @(negedge clk);
      chk("mis req",   32'(mem_req), 32'd0);
      chk("mis flag",  32'(m_misalign), 32'd1);
      chk("mis valid", 32'(m_valid), 32'd1);
      chk("mis value", m_reg_d_v, 32'd0);
      @(posedge clk); #1;
`endif

      // randomized mix of alu ops, loads and stores
      for (int n = 0; n < 40; n++) begin
         kind = int'($urandom_range(0, 2));
         base = $urandom & 32'hFFFF_FFFC;
         if (kind == 0) begin
            run_alu($sformatf("rnd%0d alu", n), 5'($urandom), $urandom);
         end else begin
            f3 = (kind == 1) ? ld_f3[$urandom_range(0, 4)] : st_f3[$urandom_range(0, 2)];
            case (f3[1:0])
               2'd0:    addr = base | 32'($urandom_range(0, 3));
               2'd1:    addr = base | (32'($urandom_range(0, 1)) << 1);
               default: addr = base;
            endcase
            case (f3[1:0])
               2'd0:    strb = 4'b0001 << addr[1:0];
               2'd1:    strb = 4'b0011 << addr[1:0];
               default: strb = 4'b1111;
            endcase
            run_access($sformatf("rnd%0d f3=%0d", n, f3), kind == 1, f3, addr, 5'($urandom),
                       $urandom, strb, $urandom, int'($urandom_range(0, 3)),
                       $urandom_range(0, 3) == 0);
         end
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
